// File: rtl/pdma_sim_mc.sv
// pdma_sim_mc -- multi-channel PDMA sink model for simulation and bring-up.
//
// Watches NUM_CH request/data-ready pairs from the acquisition FIFOs. It
// grants one channel at a time, picking channels round-robin, and pops a
// bounded burst from the granted FIFO. Popped words are counted for
// throughput checks.
//
// Optional feature macro: PDMA_SIM_CH_STATS_EN
//   defined   -> per-channel pop counters are built and driven on o_ch_pops
//   undefined -> no per-channel counters; o_ch_pops is tied to zero
//
// Ports:
//   i_clk            system clock, all logic on the rising edge
//   i_rst            synchronous reset, active-high
//   i_run            enable; low blocks new grants and aborts an active burst
//   i_pdma_irq_req   per-channel request (FIFO above threshold), level
//   i_pdma_data_rdy  per-channel FIFO not empty, level
//   o_pdma_fifo_pop  per-channel pop strobe; one-hot or zero
//   o_busy           high while in GRANT/READ/GAP
//   o_active_ch      index of the granted channel, held until the next grant
//   o_burst_done     1-cycle pulse on the cycle after a burst ends
//   o_total_pops     words popped since reset, all channels, wraps
//   o_ch_pops        per-channel words popped, ch0 in the LSBs
module pdma_sim_mc #(
  parameter  int NUM_CH     = 4,
  parameter  int BURST_MAX  = 16,
  parameter  int GAP_CYCLES = 1,
  parameter  int CNT_W      = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic [NUM_CH-1:0]       i_pdma_irq_req,
  input  logic [NUM_CH-1:0]       i_pdma_data_rdy,
  output logic [NUM_CH-1:0]       o_pdma_fifo_pop,
  output logic                    o_busy,
  output logic [CH_W-1:0]         o_active_ch,
  output logic                    o_burst_done,
  output logic [CNT_W-1:0]        o_total_pops,
  output logic [NUM_CH*CNT_W-1:0] o_ch_pops
);

  localparam int              BEAT_W    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam logic [3:0]      GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_READ,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_active_ch;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [3:0]        r_gap_cnt;
  logic              r_burst_done;
  logic [CNT_W-1:0]  r_total_pops;

  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_hi_req;
  logic [NUM_CH-1:0] w_sel;
  logic [CH_W-1:0]   w_win_hi;
  logic [CH_W-1:0]   w_win_lo;
  logic [CH_W-1:0]   w_win;
  logic [CH_W-1:0]   w_win_next;
  logic              w_any_req;
  logic              w_in_read;
  logic              w_cur_rdy;
  logic              w_pop_any;
  logic              w_last_beat;

  // Round-robin arbitration: requests at or above rr_ptr win first; if
  // none, the lowest requesting channel wins (the wrap-around case).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign w_mask[gi]          = (gi >= int'(r_rr_ptr));
      assign w_sel[gi]           = (r_active_ch == CH_W'(gi));
      // Gating on the channel's own data_rdy guarantees no pop on an empty FIFO.
      assign o_pdma_fifo_pop[gi] = w_in_read && i_run && i_pdma_data_rdy[gi] && w_sel[gi];
    end
  endgenerate

  assign w_hi_req  = i_pdma_irq_req & w_mask;
  assign w_any_req = |i_pdma_irq_req;

  always_comb begin
    w_win_hi = '0;
    w_win_lo = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_hi_req[k])       w_win_hi = CH_W'(k);
      if (i_pdma_irq_req[k]) w_win_lo = CH_W'(k);
    end
  end

  assign w_win       = (|w_hi_req) ? w_win_hi : w_win_lo;
  assign w_win_next  = (w_win == CH_LAST) ? '0 : w_win + 1'b1;

  assign w_in_read   = (r_state == S_READ);
  assign w_cur_rdy   = |(i_pdma_data_rdy & w_sel);
  assign w_pop_any   = |o_pdma_fifo_pop;
  assign w_last_beat = w_pop_any && (r_beat_cnt == BEAT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_active_ch  <= '0;
      r_beat_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_burst_done <= 1'b0;
      r_total_pops <= '0;
    end else begin
      r_burst_done <= 1'b0;
      if (w_pop_any) r_total_pops <= r_total_pops + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_run && w_any_req) r_state <= S_GRANT;
        end

        S_GRANT: begin
          // Requests may have dropped since IDLE; only grant if one remains.
          if (i_run && w_any_req) begin
            r_active_ch <= w_win;
            r_rr_ptr    <= w_win_next;
            r_beat_cnt  <= '0;
            r_state     <= S_READ;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_READ: begin
          if (w_pop_any) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (!i_run || !w_cur_rdy || w_last_beat) begin
            r_burst_done <= 1'b1;
            // An abort skips the gap so a stopped engine settles in IDLE at once.
            if (!i_run || GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
          else                       r_gap_cnt <= r_gap_cnt + 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_active_ch  = r_active_ch;
  assign o_burst_done = r_burst_done;
  assign o_total_pops = r_total_pops;

`ifdef PDMA_SIM_CH_STATS_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
      logic [CNT_W-1:0] r_ch_cnt;
      always_ff @(posedge i_clk) begin
        if (i_rst)                    r_ch_cnt <= '0;
        else if (o_pdma_fifo_pop[gi]) r_ch_cnt <= r_ch_cnt + 1'b1;
      end
      assign o_ch_pops[gi*CNT_W +: CNT_W] = r_ch_cnt;
    end
  endgenerate
`else
  assign o_ch_pops = '0;
`endif

endmodule

// File: tb/tb_pdma_sim_mc.sv
// Directed bench for pdma_sim_mc. Expected pops are queued per channel as
// stimulus is applied; every observed pop is matched against the queue head.
module tb_pdma_sim_mc;

`ifdef PDMA_SIM_CH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  irq = '0;
  logic [3:0]  rdy = '0;
  logic [3:0]  pop;
  logic        busy;
  logic [1:0]  act;
  logic        done;
  logic [15:0] tot;
  logic [63:0] chp;

  logic        run6 = 1'b0;
  logic [3:0]  irq6 = '0;
  logic [3:0]  rdy6 = '0;
  logic [3:0]  pop6;
  logic        busy6;
  logic [1:0]  act6;
  logic        done6;
  logic [3:0]  tot6;
  logic [15:0] chp6;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pdma_sim_mc #(.NUM_CH(4), .BURST_MAX(16), .GAP_CYCLES(1), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .i_pdma_irq_req(irq), .i_pdma_data_rdy(rdy),
    .o_pdma_fifo_pop(pop), .o_busy(busy), .o_active_ch(act),
    .o_burst_done(done), .o_total_pops(tot), .o_ch_pops(chp)
  );

  pdma_sim_mc #(.NUM_CH(4), .BURST_MAX(20), .GAP_CYCLES(0), .CNT_W(4)) u_dut6 (
    .i_clk(clk), .i_rst(rst), .i_run(run6),
    .i_pdma_irq_req(irq6), .i_pdma_data_rdy(rdy6),
    .o_pdma_fifo_pop(pop6), .o_busy(busy6), .o_active_ch(act6),
    .o_burst_done(done6), .o_total_pops(tot6), .o_ch_pops(chp6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input int n);
    repeat (n) exp_q.push_back(ch);
  endtask

  // Sample on the falling edge; any pop must match the scoreboard head.
  task automatic look();
    int e;
    @(negedge clk);
    if (pop !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pop", 64'(pop), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pop_channel", 64'(pop), 64'd1 << e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    look(); step();
    look();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_active", 64'(act), 64'd0);
    chk("rst_total", 64'(tot), 64'd0);
    chk("rst_chpops", chp, 64'd0);
    chk("rst_total6", 64'(tot6), 64'd0);
    step();
    rst = 1'b0;

    // T1: single 16-word burst on ch2, first pop two cycles after irq
    run = 1'b1; irq = 4'b0100; rdy = 4'b0100; push(2, 16);
    look(); chk("t1_idle_pop", 64'(pop), 64'd0); step();
    look(); chk("t1_grant_busy", 64'(busy), 64'd1); chk("t1_grant_pop", 64'(pop), 64'd0); step();
    irq = 4'b0000;
    look(); chk("t1_first_pop", 64'(pop), 64'h4); chk("t1_active", 64'(act), 64'd2); step();
    repeat (15) begin look(); step(); end
    look();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_gap_pop", 64'(pop), 64'd0);
    chk("t1_gap_busy", 64'(busy), 64'd1);
    step();
    rdy = 4'b0000;
    look();
    chk("t1_done_clear", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_total", 64'(tot), 64'd16);
    chk("t1_ch2", 64'(chp[47:32]), STATS ? 64'd16 : 64'd0);
    chk("t1_queue", 64'(exp_q.size()), 64'd0);
    step();

    // T2: ch0 FIFO runs dry after 5 pops, one GAP cycle, then IDLE
    irq = 4'b0001; rdy = 4'b0001; push(0, 5);
    look(); step(); look(); step();
    irq = 4'b0000;
    repeat (5) begin look(); step(); end
    rdy = 4'b0000;
    look(); chk("t2_dry_pop", 64'(pop), 64'd0); chk("t2_dry_done", 64'(done), 64'd0); step();
    look(); chk("t2_done", 64'(done), 64'd1); chk("t2_gap_busy", 64'(busy), 64'd1); step();
    look();
    chk("t2_idle_busy", 64'(busy), 64'd0);
    chk("t2_active", 64'(act), 64'd0);
    chk("t2_total", 64'(tot), 64'd21);
    chk("t2_queue", 64'(exp_q.size()), 64'd0);
    step();

    // Reset between tests so round-robin starts from channel 0
    rst = 1'b1; look(); step(); rst = 1'b0;
    look(); chk("rst2_total", 64'(tot), 64'd0); step();

    // T3: all channels requesting, 8 bursts in order 0,1,2,3,0,1,2,3
    irq = 4'b1111; rdy = 4'b1111;
    for (int b = 0; b < 8; b++) push(b % 4, 16);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin look(); step(); end
    irq = 4'b0000;
    chk("t3_queue", 64'(exp_q.size()), 64'd0);
    repeat (4) begin look(); step(); end
    rdy = 4'b0000;
    chk("t3_total", 64'(tot), 64'd128);
    chk("t3_chpops", chp, STATS ? 64'h0020_0020_0020_0020 : 64'd0);

    // T4: run drops on the 3rd pop cycle of a ch1 burst
    irq = 4'b0010; rdy = 4'b0010; push(1, 2);
    look(); step(); look(); step();
    irq = 4'b0000;
    look(); step(); look(); step();
    run = 1'b0;
    look(); chk("t4_abort_pop", 64'(pop), 64'd0); step();
    irq = 4'b0010;
    look(); chk("t4_idle", 64'(busy), 64'd0); chk("t4_done", 64'(done), 64'd1); step();
    repeat (5) begin look(); chk("t4_no_grant", 64'(busy), 64'd0); step(); end
    chk("t4_total", 64'(tot), 64'd130);
    chk("t4_ch1", 64'(chp[31:16]), STATS ? 64'd34 : 64'd0);
    chk("t4_queue", 64'(exp_q.size()), 64'd0);
    irq = 4'b0000; rdy = 4'b0000; run = 1'b1;

    // T5: reset during the 4th pop of a ch2 burst
    irq = 4'b0100; rdy = 4'b0100; push(2, 4);
    look(); step(); look(); step();
    irq = 4'b0000;
    repeat (3) begin look(); step(); end
    rst = 1'b1; look(); step(); rst = 1'b0;
    rdy = 4'b0000;
    look();
    chk("t5_pop", 64'(pop), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_active", 64'(act), 64'd0);
    chk("t5_total", 64'(tot), 64'd0);
    chk("t5_chpops", chp, 64'd0);
    chk("t5_queue", 64'(exp_q.size()), 64'd0);
    step();
    // rr_ptr must be back at 0: ch1 wins over ch3
    irq = 4'b1010; rdy = 4'b1010; push(1, 16);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      look();
      if (pop != 4'b0000) irq = 4'b0000;
      step();
    end
    irq = 4'b0000; rdy = 4'b0000;
    chk("t5_queue2", 64'(exp_q.size()), 64'd0);
    repeat (3) begin look(); step(); end
    chk("t5_active2", 64'(act), 64'd1);
    chk("t5_total2", 64'(tot), 64'd16);

    // T6: CNT_W=4 instance, 20 pops on ch3 wrap the counters to 4
    run6 = 1'b1; irq6 = 4'b1000; rdy6 = 4'b1000;
    look(); step();
    look(); chk("t6_grant_busy", 64'(busy6), 64'd1); step();
    irq6 = 4'b0000;
    for (int i = 0; i < 20; i++) begin look(); chk("t6_pop", 64'(pop6), 64'h8); step(); end
    look();
    chk("t6_end_pop", 64'(pop6), 64'd0);
    chk("t6_done", 64'(done6), 64'd1);
    chk("t6_idle_nogap", 64'(busy6), 64'd0);
    step();
    chk("t6_total", 64'(tot6), 64'd4);
    chk("t6_chpops", 64'(chp6), STATS ? 64'h4000 : 64'd0);
    rdy6 = 4'b0000; run6 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
